// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI data-island scheduler: packet type codes,
// FSM state encoding and the debug snapshot exported by the top level.
package hdmi_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AINFO = 8'h84;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // repeat bits flag a frame_start landing on an infoframe that was still pending
  typedef struct packed {
    state_t state;
    logic   acr_pending;
    logic   avi_pending;
    logic   ainfo_pending;
    logic   avi_repeat;
    logic   ainfo_repeat;
  } debug_t;

endpackage

// File: rtl/island_request_latch.sv
// One pending-request flag. A set in the same cycle as a clear wins, so a
// request arriving on its own grant edge is never lost.
module island_request_latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clear,
  output logic pending,
  output logic overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (set) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

  // A second request merged into one that is still outstanding.
  assign overflow = set & pending & ~clear;

endmodule

// File: rtl/data_island_scheduler.sv
// Chooses which HDMI data-island packet fills each offered slot and holds
// packet_valid/packet_type for the fixed packet length.
module data_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int PACKET_CYCLES       = 32,
  parameter int INFOFRAME_MAX_DEFER = 4,
  parameter int AUDIO_ENABLE        = 1
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       slot_open,
  input  logic       acr_wrap,
  input  logic       audio_req,
  output logic       audio_ack,
  output logic       packet_valid,
  output logic [7:0] packet_type,
  output logic       overrun,
  output debug_t     debug
);

  localparam int CW = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;
  localparam int DW = $clog2(INFOFRAME_MAX_DEFER + 1) > 0 ? $clog2(INFOFRAME_MAX_DEFER + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(PACKET_CYCLES - 1);
  localparam logic [DW-1:0] DEFER_MAX = DW'(INFOFRAME_MAX_DEFER);

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [7:0]      type_q, type_next;
  logic [DW-1:0]   defer_q, defer_next;
  logic            acr_prev;
  logic            overrun_q;

  logic acr_edge, acr_pending, avi_pending, ainfo_pending;
  logic acr_overflow, avi_overflow, ainfo_overflow;
  logic clr_acr, clr_avi, clr_ainfo;
  logic audio_ok, info_pending, promoted;

  assign acr_edge     = acr_wrap ^ acr_prev;
  assign audio_ok     = audio_req && (AUDIO_ENABLE != 0);
  assign info_pending = avi_pending || ainfo_pending;
  assign promoted     = info_pending && (defer_q == DEFER_MAX);

  island_request_latch u_acr (
    .clk(clk_pixel), .rst(reset), .set(acr_edge), .clear(clr_acr),
    .pending(acr_pending), .overflow(acr_overflow)
  );

  island_request_latch u_avi (
    .clk(clk_pixel), .rst(reset), .set(frame_start), .clear(clr_avi),
    .pending(avi_pending), .overflow(avi_overflow)
  );

  island_request_latch u_ainfo (
    .clk(clk_pixel), .rst(reset), .set(frame_start), .clear(clr_ainfo),
    .pending(ainfo_pending), .overflow(ainfo_overflow)
  );

  // Handshake: slot_open is an offer that is accepted only in IDLE; the
  // accepted packet then occupies packet_valid for exactly PACKET_CYCLES
  // cycles starting the cycle after the offer. Offers while busy are dropped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    type_next  = type_q;
    defer_next = defer_q;
    clr_acr    = 1'b0;
    clr_avi    = 1'b0;
    clr_ainfo  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_open) begin
          state_next = ST_SEND;
          cnt_next   = '0;
          if (acr_pending) begin
            type_next = PKT_ACR;
            clr_acr   = 1'b1;
          end else if (promoted && avi_pending) begin
            type_next  = PKT_AVI;
            clr_avi    = 1'b1;
            defer_next = '0;
          end else if (promoted) begin
            type_next  = PKT_AINFO;
            clr_ainfo  = 1'b1;
            defer_next = '0;
          end else if (audio_ok) begin
            type_next = PKT_AUDIO;
            if (info_pending && defer_q != DEFER_MAX) begin
              defer_next = defer_q + DW'(1);
            end
          end else if (avi_pending) begin
            type_next  = PKT_AVI;
            clr_avi    = 1'b1;
            defer_next = '0;
          end else if (ainfo_pending) begin
            type_next  = PKT_AINFO;
            clr_ainfo  = 1'b1;
            defer_next = '0;
          end else begin
            type_next = PKT_NULL;
          end
        end
      end
      ST_SEND: begin
        if (cnt == LAST_CNT) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      type_q    <= PKT_NULL;
      defer_q   <= '0;
      acr_prev  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      type_q    <= type_next;
      defer_q   <= defer_next;
      acr_prev  <= acr_wrap;
      overrun_q <= overrun_q | (slot_open && state == ST_SEND) | acr_overflow;
    end
  end

  // Outputs derive from registered state so reset clears them asynchronously.
  assign packet_valid = (state == ST_SEND);
  assign packet_type  = packet_valid ? type_q : PKT_NULL;
  assign audio_ack    = packet_valid && (cnt == '0) && (type_q == PKT_AUDIO);
  assign overrun      = overrun_q;

  always_comb begin
    debug               = '0;
    debug.state         = state;
    debug.acr_pending   = acr_pending;
    debug.avi_pending   = avi_pending;
    debug.ainfo_pending = ainfo_pending;
    debug.avi_repeat    = avi_overflow;
    debug.ainfo_repeat  = ainfo_overflow;
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler: stimulus pushes the expected packet
// type per accepted slot; a monitor pops and checks each packet as it appears.
module tb_data_island_scheduler;
  import hdmi_pkg::*;

  localparam int PKT_LEN = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       slot_open;
  logic       acr_wrap;
  logic       audio_req;
  logic       audio_ack;
  logic       packet_valid;
  logic [7:0] packet_type;
  logic       overrun;
  debug_t     debug;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  data_island_scheduler #(
    .PACKET_CYCLES(32), .INFOFRAME_MAX_DEFER(4), .AUDIO_ENABLE(1)
  ) dut (
    .clk_pixel(clk), .reset(rst), .frame_start(frame_start), .slot_open(slot_open),
    .acr_wrap(acr_wrap), .audio_req(audio_req), .audio_ack(audio_ack),
    .packet_valid(packet_valid), .packet_type(packet_type), .overrun(overrun),
    .debug(debug)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acr_wrap = 1'b0;
    slot_open = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic toggle_acr();
    acr_wrap = ~acr_wrap;
    tick();
  endtask

  task automatic send_slot(input logic [7:0] t);
    exp_q.push_back(t);
    slot_open = 1'b1;
    tick();
    slot_open = 1'b0;
    repeat (PKT_LEN + 1) tick();
  endtask

  // monitor / scoreboard
  logic       in_pkt = 1'b0;
  int         len = 0;
  logic [7:0] cur = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 1'b0;
        len = 0;
      end else if (packet_valid) begin
        if (!in_pkt) begin
          in_pkt = 1'b1;
          len = 0;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            cur = 8'hff;
            $display("FAIL unexpected_packet: got type %0h expected no packet", packet_type);
          end else begin
            cur = exp_q.pop_front();
            check("packet_type", {24'b0, packet_type}, {24'b0, cur});
            check("audio_ack_first", {31'b0, audio_ack}, {31'b0, cur == 8'h02});
          end
        end else begin
          check("type_stable", {24'b0, packet_type}, {24'b0, cur});
          check("audio_ack_later", {31'b0, audio_ack}, 32'd0);
        end
        len++;
      end else begin
        if (in_pkt) begin
          check("packet_len", len, PKT_LEN);
          in_pkt = 1'b0;
        end
        check("idle_type", {24'b0, packet_type}, 32'd0);
        check("idle_ack", {31'b0, audio_ack}, 32'd0);
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    slot_open = 1'b0;
    acr_wrap = 1'b0;
    audio_req = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", {31'b0, packet_valid}, 32'd0);
    check("rst_type", {24'b0, packet_type}, 32'd0);
    check("rst_ack", {31'b0, audio_ack}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_flags", {29'b0, debug.acr_pending, debug.avi_pending, debug.ainfo_pending}, 32'd0);
    check("rst_state", {31'b0, debug.state}, 32'd0);
    do_reset();

    // null slot
    send_slot(8'h00);
    check("null_no_overrun", {31'b0, overrun}, 32'd0);

    // ACR
    toggle_acr();
    check("acr_pending", {31'b0, debug.acr_pending}, 32'd1);
    send_slot(8'h01);

    // audio defers AVI four times, then AVI is promoted; AINFO follows
    audio_req = 1'b1;
    pulse_frame();
    repeat (4) send_slot(8'h02);
    send_slot(8'h82);
    audio_req = 1'b0;
    send_slot(8'h84);
    send_slot(8'h00);

    // ACR edge on its own grant edge stays pending
    toggle_acr();
    exp_q.push_back(8'h01);
    slot_open = 1'b1;
    acr_wrap = ~acr_wrap;
    tick();
    slot_open = 1'b0;
    repeat (PKT_LEN + 1) tick();
    send_slot(8'h01);
    send_slot(8'h00);
    check("acr_same_edge_no_overrun", {31'b0, overrun}, 32'd0);

    // repeated frame_start merges into one request each
    pulse_frame();
    pulse_frame();
    check("frame_repeat_no_overrun", {31'b0, overrun}, 32'd0);
    send_slot(8'h82);
    send_slot(8'h84);
    send_slot(8'h00);

    // slot_open at SEND cycle 10 is dropped and sets overrun
    exp_q.push_back(8'h00);
    slot_open = 1'b1;
    tick();
    slot_open = 1'b0;
    repeat (10) tick();
    slot_open = 1'b1;
    tick();
    slot_open = 1'b0;
    repeat (PKT_LEN - 10 + 2) tick();
    check("busy_slot_overrun", {31'b0, overrun}, 32'd1);

    // reset clears overrun; double ACR edge sets it and leaves one request
    do_reset();
    check("overrun_cleared", {31'b0, overrun}, 32'd0);
    toggle_acr();
    toggle_acr();
    check("acr_double_overrun", {31'b0, overrun}, 32'd1);
    send_slot(8'h01);
    send_slot(8'h00);

    // reset at SEND cycle 15 aborts the packet; acr_wrap=1 at release is one request
    pulse_frame();
    toggle_acr();
    exp_q.push_back(8'h01);
    slot_open = 1'b1;
    tick();
    slot_open = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    #1;
    check("abort_valid", {31'b0, packet_valid}, 32'd0);
    check("abort_type", {24'b0, packet_type}, 32'd0);
    check("abort_overrun", {31'b0, overrun}, 32'd0);
    check("abort_flags", {29'b0, debug.acr_pending, debug.avi_pending, debug.ainfo_pending}, 32'd0);
    acr_wrap = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("release_acr_pending", {31'b0, debug.acr_pending}, 32'd1);
    send_slot(8'h01);
    send_slot(8'h00);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
